// File: rtl/game_referee.sv
// Tank-game referee: per-frame bullet/tank collision detection, scoring,
// round sequencing (IDLE/PLAY/FREEZE/OVER) and winner reporting.
//
// state  | meaning
// IDLE   | waiting for a start edge, scores held
// PLAY   | collisions evaluated on every frame_tick
// FREEZE | post-hit pause, round_reset high, counts FREEZE_FRAMES ticks
// OVER   | a player reached WIN_SCORE, scores and winner held
module game_referee #(
  parameter int COORD_W       = 10,
  parameter int TANK_SIZE     = 16,
  parameter int BUL_SIZE      = 4,
  parameter int WIN_SCORE     = 5,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [COORD_W-1:0] tank1_x,
  input  logic [COORD_W-1:0] tank1_y,
  input  logic [COORD_W-1:0] tank2_x,
  input  logic [COORD_W-1:0] tank2_y,
  input  logic [COORD_W-1:0] bul1_x,
  input  logic [COORD_W-1:0] bul1_y,
  input  logic [COORD_W-1:0] bul2_x,
  input  logic [COORD_W-1:0] bul2_y,
  input  logic               bul1_active,
  input  logic               bul2_active,
  output logic [3:0]         score1,
  output logic [3:0]         score2,
  output logic [1:0]         state,
  output logic               hit1,
  output logic               hit2,
  output logic               round_reset,
  output logic [1:0]         winner
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_PLAY   = 2'b01;
  localparam logic [1:0] S_FREEZE = 2'b10;
  localparam logic [1:0] S_OVER   = 2'b11;

  localparam int CNT_W = $clog2(FREEZE_FRAMES + 1);
  localparam logic [COORD_W:0] TANK_SPAN   = (COORD_W+1)'(TANK_SIZE - 1);
  localparam logic [COORD_W:0] BUL_SPAN    = (COORD_W+1)'(BUL_SIZE - 1);
  localparam logic [3:0]       WIN         = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_FRAMES - 1);

  // One extra bit keeps lo+SIZE-1 from wrapping near the top of the coordinate range.
  function automatic logic axis_overlap(input logic [COORD_W-1:0] bul_lo,
                                        input logic [COORD_W-1:0] tank_lo);
    logic [COORD_W:0] b_lo, b_hi, t_lo, t_hi;
    b_lo = {1'b0, bul_lo};
    b_hi = b_lo + BUL_SPAN;
    t_lo = {1'b0, tank_lo};
    t_hi = t_lo + TANK_SPAN;
    return (b_lo <= t_hi) && (t_lo <= b_hi);
  endfunction

  logic             start_q;
  logic             start_rise;
  logic             strike1, strike2;
  logic             raw_hit1, raw_hit2;
  logic [3:0]       next1, next2;
  logic [CNT_W-1:0] freeze_cnt;

  assign start_rise  = start & ~start_q;
  assign round_reset = (state == S_FREEZE);

  always_comb begin
    strike1 = bul1_active && axis_overlap(bul1_x, tank2_x) && axis_overlap(bul1_y, tank2_y);
    strike2 = bul2_active && axis_overlap(bul2_x, tank1_x) && axis_overlap(bul2_y, tank1_y);
    next1   = (raw_hit1 && (score1 != WIN)) ? score1 + 4'd1 : score1;
    next2   = (raw_hit2 && (score2 != WIN)) ? score2 + 4'd1 : score2;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      score1     <= 4'd0;
      score2     <= 4'd0;
      winner     <= 2'b00;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      raw_hit1   <= 1'b0;
      raw_hit2   <= 1'b0;
      freeze_cnt <= '0;
      start_q    <= start;
    end else begin
      start_q  <= start;
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      raw_hit1 <= frame_tick && (state == S_PLAY) && strike1;
      raw_hit2 <= frame_tick && (state == S_PLAY) && strike2;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            state  <= S_PLAY;
            score1 <= 4'd0;
            score2 <= 4'd0;
            winner <= 2'b00;
          end
        end
        S_PLAY: begin
          if (raw_hit1 || raw_hit2) begin
            hit1   <= raw_hit1;
            hit2   <= raw_hit2;
            score1 <= next1;
            score2 <= next2;
            if ((next1 == WIN) || (next2 == WIN)) begin
              state  <= S_OVER;
              winner <= {next2 == WIN, next1 == WIN};
            end else begin
              state      <= S_FREEZE;
              freeze_cnt <= '0;
            end
          end
        end
        S_FREEZE: begin
          if (frame_tick) begin
            freeze_cnt <= freeze_cnt + CNT_W'(1);
            if (freeze_cnt == FREEZE_LAST) state <= S_PLAY;
          end
        end
        S_OVER: begin
          if (start_rise) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: directed vector table, multi-cycle round sequences,
// and randomized frames compared against a frame-level reference model.
module tb_game_referee;
  localparam int CW = 10, TS = 16, BS = 4, WIN = 5, FF = 60;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_FREEZE = 2, ST_OVER = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, frame_tick = 1'b0, start = 1'b0;
  logic [CW-1:0] t1x = '0, t1y = '0, t2x = '0, t2y = '0;
  logic [CW-1:0] b1x = '0, b1y = '0, b2x = '0, b2y = '0;
  logic b1a = 1'b0, b2a = 1'b0;
  logic [3:0] score1, score2;
  logic [1:0] state, winner;
  logic hit1, hit2, round_reset;

  int n_pass = 0, n_total = 0;

  game_referee #(.COORD_W(CW), .TANK_SIZE(TS), .BUL_SIZE(BS),
                 .WIN_SCORE(WIN), .FREEZE_FRAMES(FF)) dut (
    .Clk(clk), .Reset(reset), .frame_tick(frame_tick), .start(start),
    .tank1_x(t1x), .tank1_y(t1y), .tank2_x(t2x), .tank2_y(t2y),
    .bul1_x(b1x), .bul1_y(b1y), .bul2_x(b2x), .bul2_y(b2y),
    .bul1_active(b1a), .bul2_active(b2a),
    .score1(score1), .score2(score2), .state(state),
    .hit1(hit1), .hit2(hit2), .round_reset(round_reset), .winner(winner));

  typedef struct {
    int b1x, b1y; bit b1a;
    int b2x, b2y; bit b2a;
    int t1x, t1y, t2x, t2y;
    bit h1, h2;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(int ab1x, int ab1y, bit ab1a, int ab2x, int ab2y, bit ab2a,
                              int at1x, int at1y, int at2x, int at2y, bit eh1, bit eh2);
    vec_t v;
    v.b1x = ab1x; v.b1y = ab1y; v.b1a = ab1a;
    v.b2x = ab2x; v.b2y = ab2y; v.b2a = ab2a;
    v.t1x = at1x; v.t1y = at1y; v.t2x = at2x; v.t2y = at2y;
    v.h1 = eh1; v.h2 = eh2;
    return v;
  endfunction

  function automatic bit ov(int bx, int by, int tx, int ty);
    return (bx <= tx + TS - 1) && (tx <= bx + BS - 1) &&
           (by <= ty + TS - 1) && (ty <= by + BS - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t v);
    b1x = CW'(v.b1x); b1y = CW'(v.b1y); b1a = v.b1a;
    b2x = CW'(v.b2x); b2y = CW'(v.b2y); b2a = v.b2a;
    t1x = CW'(v.t1x); t1y = CW'(v.t1y); t2x = CW'(v.t2x); t2y = CW'(v.t2y);
  endtask

  task automatic reset_and_start();
    @(negedge clk); reset = 1; start = 0; frame_tick = 0;
    @(negedge clk); reset = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
  endtask

  // Ends two cycles after the tick, where hit pulses are visible.
  task automatic frame();
    frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    @(negedge clk);
  endtask

  task automatic freeze_out();
    repeat (FF) begin
      frame_tick = 1;
      @(negedge clk); frame_tick = 0;
      @(negedge clk);
    end
  endtask

  task automatic start_pulse();
    start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_state, m_s1, m_s2, m_win, m_cnt;
    bit h1, h2, any_hit;

    vecs[0] = mk(100, 100, 1, 0, 0, 0, 300, 300, 90, 90, 1, 0);
    vecs[1] = mk(0, 0, 0, 115, 50, 1, 100, 50, 600, 300, 0, 1);
    vecs[2] = mk(0, 0, 0, 116, 50, 1, 100, 50, 600, 300, 0, 0);
    vecs[3] = mk(104, 54, 1, 0, 0, 0, 100, 50, 600, 300, 0, 0);
    vecs[4] = mk(2, 0, 1, 0, 0, 0, 300, 300, 1020, 0, 0, 0);
    vecs[5] = mk(100, 100, 0, 0, 0, 0, 300, 300, 90, 90, 0, 0);
    vecs[6] = mk(90, 87, 1, 305, 310, 1, 300, 300, 90, 90, 1, 1);
    vecs[7] = mk(90, 86, 1, 0, 0, 0, 300, 300, 90, 90, 0, 0);

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_state", state, ST_IDLE);
    check("rst_score1", score1, 0);
    check("rst_score2", score2, 0);
    check("rst_hits", {hit1, hit2}, 0);
    check("rst_round_reset", round_reset, 0);
    check("rst_winner", winner, 0);

    // Directed vectors, each from a fresh game
    for (int i = 0; i < 8; i++) begin
      reset_and_start();
      check($sformatf("vec%0d_play", i), state, ST_PLAY);
      apply(vecs[i]);
      frame();
      check($sformatf("vec%0d_hit1", i), hit1, vecs[i].h1);
      check($sformatf("vec%0d_hit2", i), hit2, vecs[i].h2);
      check($sformatf("vec%0d_score1", i), score1, vecs[i].h1);
      check($sformatf("vec%0d_score2", i), score2, vecs[i].h2);
      check($sformatf("vec%0d_state", i), state,
            (vecs[i].h1 || vecs[i].h2) ? ST_FREEZE : ST_PLAY);
      @(negedge clk);
    end

    // Hit latency and freeze duration
    reset_and_start();
    apply(vecs[0]);
    frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    check("lat_hit1_early", hit1, 0);
    @(negedge clk);
    check("lat_hit1", hit1, 1);
    check("lat_score1", score1, 1);
    check("lat_state", state, ST_FREEZE);
    check("lat_round_reset", round_reset, 1);
    @(negedge clk);
    check("lat_hit1_one_cycle", hit1, 0);
    apply(vecs[6]);
    any_hit = 0;
    repeat (FF - 1) begin
      frame_tick = 1;
      @(negedge clk); frame_tick = 0; any_hit |= hit1 | hit2;
      @(negedge clk); any_hit |= hit1 | hit2;
    end
    check("frz59_state", state, ST_FREEZE);
    check("frz59_round_reset", round_reset, 1);
    frame_tick = 1;
    @(negedge clk); frame_tick = 0; any_hit |= hit1 | hit2;
    check("frz60_state", state, ST_PLAY);
    check("frz60_round_reset", round_reset, 0);
    @(negedge clk); @(negedge clk); any_hit |= hit1 | hit2;
    check("frz_no_hits", any_hit, 0);
    check("frz_score1", score1, 1);
    check("frz_score2", score2, 0);

    // Simultaneous win to draw, then OVER -> IDLE -> PLAY
    reset_and_start();
    apply(vecs[6]);
    repeat (4) begin
      frame(); @(negedge clk); freeze_out();
    end
    check("pre_draw_score1", score1, 4);
    check("pre_draw_score2", score2, 4);
    check("pre_draw_state", state, ST_PLAY);
    frame();
    check("draw_hits", {hit1, hit2}, 2'b11);
    check("draw_score1", score1, 5);
    check("draw_score2", score2, 5);
    check("draw_winner", winner, 3);
    check("draw_state", state, ST_OVER);
    @(negedge clk);
    frame(); @(negedge clk);
    check("over_tick_score1", score1, 5);
    check("over_tick_state", state, ST_OVER);
    start_pulse();
    check("over_to_idle", state, ST_IDLE);
    start_pulse();
    check("idle_to_play", state, ST_PLAY);
    check("new_game_score1", score1, 0);
    check("new_game_score2", score2, 0);
    check("new_game_winner", winner, 0);
    start_pulse();
    check("start_in_play_ignored", state, ST_PLAY);

    // Reset during FREEZE with a held start key
    reset_and_start();
    apply(vecs[0]);
    repeat (2) begin
      frame(); @(negedge clk); freeze_out();
    end
    frame();
    check("pre_rst_score1", score1, 3);
    check("pre_rst_state", state, ST_FREEZE);
    start = 1;
    @(negedge clk);
    check("start_in_freeze_ignored", state, ST_FREEZE);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("frz_rst_state", state, ST_IDLE);
    check("frz_rst_score1", score1, 0);
    check("frz_rst_round_reset", round_reset, 0);
    check("frz_rst_winner", winner, 0);
    repeat (3) @(negedge clk);
    check("held_start_no_edge", state, ST_IDLE);
    start = 0;
    @(negedge clk);

    // Randomized frames against the reference model
    reset_and_start();
    m_state = ST_PLAY; m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0;
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        if (m_state == ST_IDLE) begin
          m_state = ST_PLAY; m_s1 = 0; m_s2 = 0; m_win = 0;
        end else if (m_state == ST_OVER) m_state = ST_IDLE;
        start_pulse();
        check("rnd_start_state", state, m_state);
      end
      t1x = CW'($urandom_range(0, 1023)); t1y = CW'($urandom_range(0, 1023));
      t2x = CW'($urandom_range(0, 1023)); t2y = CW'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) begin
        b1x = CW'(int'(t2x) + $urandom_range(0, 24) - 6);
        b1y = CW'(int'(t2y) + $urandom_range(0, 24) - 6);
      end else begin
        b1x = CW'($urandom_range(0, 1023)); b1y = CW'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 1) == 1) begin
        b2x = CW'(int'(t1x) + $urandom_range(0, 24) - 6);
        b2y = CW'(int'(t1y) + $urandom_range(0, 24) - 6);
      end else begin
        b2x = CW'($urandom_range(0, 1023)); b2y = CW'($urandom_range(0, 1023));
      end
      b1a = ($urandom_range(0, 3) != 0);
      b2a = ($urandom_range(0, 3) != 0);

      h1 = 0; h2 = 0;
      if (m_state == ST_PLAY) begin
        h1 = b1a && ov(int'(b1x), int'(b1y), int'(t2x), int'(t2y));
        h2 = b2a && ov(int'(b2x), int'(b2y), int'(t1x), int'(t1y));
        if (h1 || h2) begin
          m_s1 = (m_s1 + int'(h1) > WIN) ? WIN : m_s1 + int'(h1);
          m_s2 = (m_s2 + int'(h2) > WIN) ? WIN : m_s2 + int'(h2);
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_state = ST_OVER;
            m_win = (m_s1 == WIN ? 1 : 0) + (m_s2 == WIN ? 2 : 0);
          end else begin
            m_state = ST_FREEZE; m_cnt = 0;
          end
        end
      end else if (m_state == ST_FREEZE) begin
        m_cnt++;
        if (m_cnt == FF) m_state = ST_PLAY;
      end

      frame();
      check("rnd_hit1", hit1, h1);
      check("rnd_hit2", hit2, h2);
      check("rnd_state", state, m_state);
      check("rnd_round_reset", round_reset, m_state == ST_FREEZE);
      if (m_state != ST_IDLE) begin
        check("rnd_score1", score1, m_s1);
        check("rnd_score2", score2, m_s2);
        check("rnd_winner", winner, m_win);
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/game_referee.md
Name: game_referee

Overview:
- Downstream of the two tank instances. Consumes tank and bullet positions once per frame and detects bullet-on-enemy-tank hits.
- Keeps per-player scores, sequences rounds (play, freeze, game over), and supplies score digits and the winner to the HEX/LED path.
- Drives the round-reset request that re-spawns the tanks after a hit.

Parameters:
- COORD_W, 10, width of every x/y coordinate port.
- TANK_SIZE, 16, tank bounding-box edge in pixels.
- BUL_SIZE, 4, bullet bounding-box edge in pixels.
- WIN_SCORE, 5, score that ends the game (must be ≤ 9).
- FREEZE_FRAMES, 60, frame_tick count spent in FREEZE after a hit.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-Clk-cycle pulse per game frame.
- start  in  1  level start request from a key. A rising edge is the start event.
- tank1_x, tank1_y  in  COORD_W each  player-1 tank top-left corner.
- tank2_x, tank2_y  in  COORD_W each  player-2 tank top-left corner.
- bul1_x, bul1_y  in  COORD_W each  player-1 bullet top-left corner.
- bul2_x, bul2_y  in  COORD_W each  player-2 bullet top-left corner.
- bul1_active, bul2_active  in  1 each  bullet currently in flight.
- score1, score2  out  4 each  BCD score, 0..WIN_SCORE.
- state  out  2  00 IDLE, 01 PLAY, 10 FREEZE, 11 OVER.
- hit1, hit2  out  1 each  one-cycle pulse. hit1 = P1 bullet struck tank2. hit2 = P2 bullet struck tank1.
- round_reset  out  1  high for the whole FREEZE state.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- Reset values: state=IDLE, scores=0, hit1/hit2=0, round_reset=0, winner=00, freeze counter=0. The start edge detector is preloaded with the current start level, so a held key does not count as an edge.
- Reset asserted in any state returns all of the above on the next Clk edge. Reset has priority over every other event.
- Overlap test, per axis: a_lo ≤ b_hi AND b_lo ≤ a_hi. Hi = lo + SIZE − 1, computed at COORD_W+1 bits so there is no wrap-around. A coordinate near 2^COORD_W−1 must not alias to 0.
- Hits counted: P1 bullet vs tank2 and P2 bullet vs tank1 only. Own-bullet vs own-tank is ignored. An inactive bullet never hits.
- Pipeline stage 1: on a frame_tick cycle while state=PLAY, register raw_hit1 and raw_hit2.
- Pipeline stage 2: on the next cycle, pulse hit1/hit2 and update scores. Total latency is 2 Clk cycles from frame_tick.
- Inputs are sampled only on frame_tick cycles. Ticks in IDLE, FREEZE and OVER evaluate no collisions.
- Score update: increment at most once per frame per player and saturate at WIN_SCORE.
- Simultaneous hits: both scores increment in the same cycle.
- Transitions:
  - IDLE → PLAY on a start rising edge. Scores are cleared and winner=00.
  - PLAY → OVER on the stage-2 cycle if either updated score equals WIN_SCORE. Winner = 01, 10, or 11 if both reach it together.
  - PLAY → FREEZE on the stage-2 cycle on any other hit. The freeze counter clears and round_reset rises in the same cycle.
  - FREEZE → PLAY when the counter, incremented per frame_tick, reaches FREEZE_FRAMES. round_reset falls in that cycle.
  - OVER holds scores and winner. OVER → IDLE on a start rising edge.
- A start edge in PLAY or FREEZE is ignored.
- hit1/hit2 are never high outside the stage-2 cycle. A hit may coincide with the transition into FREEZE or OVER.

Test Plan:
- Reset, then start edge, then frame_tick with bul1_active=1, bul1=(100,100), tank2=(90,90) → hit1 pulses 2 cycles after tick; score1=1; state=FREEZE; round_reset=1.
- In FREEZE, issue 59 frame_ticks → still FREEZE. 60th tick → state=PLAY and round_reset=0. Bullet overlaps during FREEZE ticks → score unchanged.
- Edge overlap: bul2=(115,50), tank1=(100,50) → hit (115 ≤ 115). bul2=(116,50) → no hit. bul1 on own tank1 → no hit.
- Wrap check: tank2=(1020,0), bul1=(2,0) with bul1_active=1 → no hit.
- Scores 4/4, both bullets hit on the same tick → score1=score2=5, winner=11, state=OVER. A second start edge → IDLE. A third → PLAY with scores 0.
- Assert Reset during FREEZE with score1=3 → next cycle: IDLE, scores 0, round_reset=0. A held start key after Reset produces no transition.
